signature_checker: RTL and testbench

SIGNATURE_CHECKER -- requirements
Module: signature_checker

---
 rtl/signature_checker.sv | 145 ++++++++++++++
 tb/tb_signature_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/signature_checker.sv
// signature_checker
//   Watches a bus (for example a CPU LED port) after a start pulse and decides
//   whether it settles on a golden signature.  A run passes once the masked
//   bus has matched EXPECTED on STABLE consecutive clock edges.  It fails if
//   TIMEOUT edges go by without a pass.  While the run is active the block
//   also counts bus transitions and keeps the most recent sample.
//
// Ports
//   i_clk        : single clock, rising edge
//   i_arst_n     : asynchronous active-low reset
//   i_start      : one-cycle pulse, begins/restarts a run (ignored while busy)
//   i_data       : monitored bus, synchronous to i_clk
//   o_busy       : high exactly while a run is in progress
//   o_pass       : level, the last run ended with a stable match
//   o_fail       : level, the last run ended by timeout
//   o_change_cnt : i_data transitions seen in the current/last run (saturating)
//   o_last       : i_data sampled at the most recent RUN edge
//   o_dbg_state  : current FSM state (0 IDLE, 1 RUN, 2 PASS, 3 FAIL)
//
// Handshake: i_start is a plain pulse with no ready.  It is accepted on any
// edge where o_busy is low and dropped on any edge where o_busy is high.
module signature_checker #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] EXPECTED = 16'h5003,
  parameter logic [WIDTH-1:0] MASK     = '1,
  parameter int               TIMEOUT  = 7500,
  parameter int               STABLE   = 4,
  parameter int               CNT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_busy,
  output logic             o_pass,
  output logic             o_fail,
  output logic [CNT_W-1:0] o_change_cnt,
  output logic [WIDTH-1:0] o_last,
  output logic [1:0]       o_dbg_state
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int MCH_W = $clog2(STABLE + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [MCH_W-1:0]   mch_q, mch_d;
  logic [CNT_W-1:0]   chg_q, chg_d;
  logic [WIDTH-1:0]   last_q, last_d;
  logic               busy_q, busy_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;

  logic match;
  logic pass_hit;
  logic tmo_hit;

  assign match    = ((i_data & MASK) == (EXPECTED & MASK));
  // Both limits are tested on the value the counter is about to take, so the
  // verdict is registered on the very edge that completes the condition.
  assign pass_hit = match && ((int'(mch_q) + 1) == STABLE);
  assign tmo_hit  = ((int'(tmo_q) + 1) == TIMEOUT);

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    mch_d   = mch_q;
    chg_d   = chg_q;
    last_d  = last_q;
    busy_d  = busy_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      ST_RUN: begin
        last_d = i_data;
        tmo_d  = tmo_q + TMO_W'(1);
        mch_d  = match ? (mch_q + MCH_W'(1)) : '0;
        // Saturate instead of wrapping so a very busy bus never reads as quiet.
        if ((i_data != last_q) && (chg_q != {CNT_W{1'b1}})) begin
          chg_d = chg_q + CNT_W'(1);
        end
        // Pass is checked first: a match completing on the timeout edge wins.
        if (pass_hit) begin
          state_d = ST_PASS;
          busy_d  = 1'b0;
          pass_d  = 1'b1;
        end else if (tmo_hit) begin
          state_d = ST_FAIL;
          busy_d  = 1'b0;
          fail_d  = 1'b1;
        end
      end
      default: begin
        // IDLE, PASS and FAIL all hold their outputs until the next start.
        if (i_start) begin
          state_d = ST_RUN;
          tmo_d   = '0;
          mch_d   = '0;
          chg_d   = '0;
          last_d  = i_data;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      mch_q   <= '0;
      chg_q   <= '0;
      last_q  <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      mch_q   <= mch_d;
      chg_q   <= chg_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign o_busy       = busy_q;
  assign o_pass       = pass_q;
  assign o_fail       = fail_q;
  assign o_change_cnt = chg_q;
  assign o_last       = last_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_signature_checker.sv
// Bench for signature_checker.  Two instances share all inputs:
//   dut_a : full mask, 8-bit change counter
//   dut_b : MASK 16'hFF00, 3-bit change counter (saturates at 7)
// Both use TIMEOUT=20, STABLE=4, EXPECTED=16'h5003.
module tb_signature_checker;

  localparam int W = 16;

  logic         clk;
  logic         arst_n;
  logic         start;
  logic [W-1:0] data;

  logic         busy_a, pass_a, fail_a;
  logic [7:0]   chg_a;
  logic [W-1:0] last_a;
  logic [1:0]   st_a;
  logic         busy_b, pass_b, fail_b;
  logic [2:0]   chg_b;
  logic [W-1:0] last_b;
  logic [1:0]   st_b;

  int checks = 0;
  int errors = 0;

  signature_checker #(
    .WIDTH(16), .EXPECTED(16'h5003), .MASK(16'hFFFF),
    .TIMEOUT(20), .STABLE(4), .CNT_W(8)
  ) dut_a (
    .i_clk(clk), .i_arst_n(arst_n), .i_start(start), .i_data(data),
    .o_busy(busy_a), .o_pass(pass_a), .o_fail(fail_a),
    .o_change_cnt(chg_a), .o_last(last_a), .o_dbg_state(st_a)
  );

  signature_checker #(
    .WIDTH(16), .EXPECTED(16'h5003), .MASK(16'hFF00),
    .TIMEOUT(20), .STABLE(4), .CNT_W(3)
  ) dut_b (
    .i_clk(clk), .i_arst_n(arst_n), .i_start(start), .i_data(data),
    .o_busy(busy_b), .o_pass(pass_b), .o_fail(fail_b),
    .o_change_cnt(chg_b), .o_last(last_b), .o_dbg_state(st_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scenario table ----------------
  // mode 0: constant v on every edge
  // mode 1: 5003 at start edge and edge 1, then edge e even -> 5002, odd -> 5003
  // mode 2: 0000 before RUN edge 17, 5003 from edge 17 on
  // mode 3: edge e even -> 0000, odd -> 0001
  typedef struct {
    int           mode;
    logic [W-1:0] v;
    int           restart_at;
    int           done_a;
    logic         pass_a;
    logic         fail_a;
    int           chg_a;
    logic [W-1:0] last_a;
    int           done_b;
    logic         pass_b;
    logic         fail_b;
    int           chg_b;
    logic [W-1:0] last_b;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  function automatic logic [W-1:0] data_at(input int mode, input logic [W-1:0] v, input int e);
    logic [W-1:0] r;
    r = v;
    case (mode)
      1: r = (e < 2) ? 16'h5003 : ((e % 2 == 0) ? 16'h5002 : 16'h5003);
      2: r = (e < 17) ? 16'h0000 : 16'h5003;
      3: r = (e % 2 == 0) ? 16'h0000 : 16'h0001;
      default: r = v;
    endcase
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Pulses start, then feeds data per RUN edge until both instances leave RUN.
  // done_* is the RUN edge after which busy dropped, -1 if it never did.
  task automatic do_run(input int mode, input logic [W-1:0] v, input int restart_at,
                        output int done_a, output int done_b);
    int cur;
    start = 1'b1;
    data  = data_at(mode, v, 0);
    step();
    start  = 1'b0;
    cur    = 0;
    done_a = -1;
    done_b = -1;
    while (cur < 40 && (done_a < 0 || done_b < 0)) begin
      if (!busy_a && done_a < 0) done_a = cur;
      if (!busy_b && done_b < 0) done_b = cur;
      if (done_a >= 0 && done_b >= 0) break;
      data  = data_at(mode, v, cur + 1);
      start = (cur + 1 == restart_at);
      step();
      start = 1'b0;
      cur++;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_pass"}, 32'(pass_a), 32'd0);
    chk({tag, "_fail"}, 32'(fail_a), 32'd0);
    chk({tag, "_chg"},  32'(chg_a),  32'd0);
    chk({tag, "_last"}, 32'(last_a), 32'd0);
    chk({tag, "_st"},   32'(st_a),   32'd0);
    chk({tag, "_b_busy"}, 32'(busy_b), 32'd0);
  endtask

  initial begin
    int da, db;

    vecs[0] = '{0, 16'h5003, -1,  4, 1'b1, 1'b0,  0, 16'h5003,  4, 1'b1, 1'b0, 0, 16'h5003};
    vecs[1] = '{3, 16'h0000, -1, 20, 1'b0, 1'b1, 20, 16'h0000, 20, 1'b0, 1'b1, 7, 16'h0000};
    vecs[2] = '{0, 16'h50AA, -1, 20, 1'b0, 1'b1,  0, 16'h50AA,  4, 1'b1, 1'b0, 0, 16'h50AA};
    vecs[3] = '{1, 16'h0000, -1, 20, 1'b0, 1'b1, 19, 16'h5002,  4, 1'b1, 1'b0, 3, 16'h5002};
    vecs[4] = '{0, 16'h0000, -1, 20, 1'b0, 1'b1,  0, 16'h0000, 20, 1'b0, 1'b1, 0, 16'h0000};
    vecs[5] = '{2, 16'h0000, -1, 20, 1'b1, 1'b0,  1, 16'h5003, 20, 1'b1, 1'b0, 1, 16'h5003};
    vecs[6] = '{0, 16'h0000,  2, 20, 1'b0, 1'b1,  0, 16'h0000, 20, 1'b0, 1'b1, 0, 16'h0000};

    arst_n = 1'b0;
    start  = 1'b0;
    data   = 16'h1234;
    #12;
    check_zero("reset");
    step();
    step();
    arst_n = 1'b1;
    step();
    step();
    check_zero("idle_after_reset");

    for (int i = 0; i < NV; i++) begin
      do_run(vecs[i].mode, vecs[i].v, vecs[i].restart_at, da, db);
      chk($sformatf("v%0d_done_a", i), 32'(da), 32'(vecs[i].done_a));
      chk($sformatf("v%0d_done_b", i), 32'(db), 32'(vecs[i].done_b));
      // Verdicts and counters must hold for a few idle cycles.
      step();
      step();
      step();
      chk($sformatf("v%0d_pass_a", i), 32'(pass_a), 32'(vecs[i].pass_a));
      chk($sformatf("v%0d_fail_a", i), 32'(fail_a), 32'(vecs[i].fail_a));
      chk($sformatf("v%0d_chg_a", i),  32'(chg_a),  32'(vecs[i].chg_a));
      chk($sformatf("v%0d_last_a", i), 32'(last_a), 32'(vecs[i].last_a));
      chk($sformatf("v%0d_st_a", i),   32'(st_a),   vecs[i].pass_a ? 32'd2 : 32'd3);
      chk($sformatf("v%0d_pass_b", i), 32'(pass_b), 32'(vecs[i].pass_b));
      chk($sformatf("v%0d_fail_b", i), 32'(fail_b), 32'(vecs[i].fail_b));
      chk($sformatf("v%0d_chg_b", i),  32'(chg_b),  32'(vecs[i].chg_b));
      chk($sformatf("v%0d_last_b", i), 32'(last_b), 32'(vecs[i].last_b));
    end

    // Reset in the middle of a run: start with 0000, reset during RUN edge 10.
    start = 1'b1;
    data  = 16'h0000;
    step();
    start = 1'b0;
    chk("mid_busy_start", 32'(busy_a), 32'd1);
    chk("mid_st_run", 32'(st_a), 32'd1);
    data = 16'h0F0F;
    for (int e = 1; e < 10; e++) step();
    chk("mid_chg_before_reset", 32'(chg_a), 32'd1);
    @(posedge clk);
    #3;
    arst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    step();
    step();
    arst_n = 1'b1;
    data   = 16'h5003;
    step();
    step();
    step();
    check_zero("mid_after_release");

    // Fresh run after the aborted one starts from cleared counters.
    do_run(0, 16'h5003, -1, da, db);
    chk("fresh_done_a", 32'(da), 32'd4);
    chk("fresh_pass_a", 32'(pass_a), 32'd1);
    chk("fresh_fail_a", 32'(fail_a), 32'd0);
    chk("fresh_chg_a", 32'(chg_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
